exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline. Sits directly downstream of the ID/EX pipeline register and feeds the EX/MEM pipeline register.
- Generates Val2 (immediate rotate, register shift or memory offset) and runs the ALU.
- Holds the architectural NZCV status register and computes the branch target.
- Executes MUL as a multi-cycle radix-4 iterative operation, stalling upstream stages while it runs.

Parameters:
- N, 32, datapath width. Only 32 is supported.
- MUL_CYCLES, 16, radix-4 iterations per MUL (N/2).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  branch-taken squash. Aborts the in-flight MUL and suppresses the status update.
- PC  in  32  PC+4 of the instruction in EX.
- WB_EN, MEM_R_EN, MEM_W_EN, B, S  in  1 each  control bits from the ID/EX register.
- EXE_CMD  in  4  ALU opcode.
- Val_Rn, Val_Rm  in  32  register operands.
- imm  in  1  I bit: selects the immediate form of the shifter operand.
- Shift_operand  in  12  ARM shifter operand field.
- Signed_imm_24  in  24  branch offset.
- ALU_Res  out  32  ALU or MUL result to EX/MEM.
- Br_Addr  out  32  branch target.
- Status  out  4  {N,Z,C,V} status register, to the ID condition check.
- stall_mul  out  1  freezes PC, IF/ID and ID/EX. Bubbles EX/MEM.
- WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out  out  1 each  pass-through of the inputs. Forced to 0 while stall_mul=1.

Behaviour:
- Val2 selection:
  - If MEM_R_EN|MEM_W_EN: Val2 = sign-extend(Shift_operand[11:0]).
  - Else if imm: Val2 = {24'b0, Shift_operand[7:0]} rotated right by 2*Shift_operand[11:8].
  - Else: Val_Rm shifted by Shift_operand[11:7] using type Shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes Val_Rm unchanged.
- EXE_CMD encodings, Cin = Status C:
  - 0001 MOV: Val2.
  - 1001 MVN: ~Val2.
  - 0010 ADD (also LDR/STR address): Rn+Val2.
  - 0011 ADC: Rn+Val2+Cin.
  - 0100 SUB/CMP: Rn-Val2.
  - 0101 SBC: Rn-Val2-!Cin.
  - 0110 AND/TST.
  - 0111 ORR.
  - 1000 EOR.
  - 1010 MUL: Rn*Rm, low 32 bits.
  - Any other value: result 0, flags unchanged.
- Flag rules:
  - N = res[31]. Z = (res==0).
  - C = carry-out for add ops; NOT borrow for subtract ops; unchanged for logic, MOV/MVN and MUL.
  - V = signed overflow for add/sub ops; unchanged otherwise.
- Combinational ops: ALU_Res is valid in the same cycle, with no added latency.
- Br_Addr = PC + (sign-extend(Signed_imm_24) << 2), computed combinationally every cycle.
- Status register:
  - Reset to 4'b0.
  - Loaded at posedge clk when S=1, flush=0, stall_mul=0 and the op is not undefined.
  - MUL with S loads N and Z only, at the DONE cycle.
- MUL state machine, IDLE/BUSY/DONE:
  - IDLE: on EXE_CMD=1010 and flush=0, latch multiplicand=Val_Rn, multiplier=Val_Rm, acc=0, cnt=0, then go to BUSY. stall_mul is asserted combinationally in this cycle.
  - BUSY, each cycle:
    - acc += (multiplicand * multiplier[1:0]) << (2*cnt), mod 2^32.
    - multiplier >>= 2; cnt++.
    - When cnt==MUL_CYCLES-1, go to DONE.
    - stall_mul=1 throughout.
  - DONE: stall_mul=0, ALU_Res=acc, control bits pass through, flags update if S. Then return to IDLE.
  - The ID/EX register is held, so MUL remains presented during DONE. The FSM ignores EXE_CMD in DONE and does not restart.
  - Timing: stall_mul is high for MUL_CYCLES+1 = 17 cycles (the launch cycle plus 16 BUSY cycles), then low for the DONE cycle. Total stage occupancy is 18 cycles.
- flush in any state: return to IDLE next edge, drop stall_mul, no status write.
- rst mid-operation: FSM to IDLE, acc=0, cnt=0, Status=0, stall_mul=0 immediately (asynchronous).
- Reset values: Status=0, stall_mul=0. All other outputs are combinational from inputs and the zeroed state.

Test Plan:
- Reset then ADD, S=1, Rn=5, imm=1, Shift_operand=0x007 -> ALU_Res=12, Status=0000 after the edge.
- ADD S=1, Rn=0x7FFFFFFF, Val2=1 -> ALU_Res=0x80000000, Status=N1 Z0 C0 V1.
- SUB S=1, Rn=3, Val2=5 -> 0xFFFFFFFE, Status=1000. Then ADC Rn=1, Val2=1 -> 2 (Cin=0).
- Register shift, Rm=0x80000001, ASR #1 with MOV -> 0xC0000000. Immediate 0xFF rotate 4 (2*2) -> 0xF000000F. STR with offset 0xFFC, Rn=0x100 -> 0xFC.
- MUL Rn=0x00010003, Rm=7 -> stall_mul high exactly 17 cycles, then ALU_Res=0x00070015 in the DONE cycle. With S=1, N=0, Z=0 and C/V preserved. Also MUL Rn=Rm=0xFFFFFFFF -> 0x00000001.
- flush asserted at BUSY cycle 5 -> stall_mul low next cycle, Status unchanged. A following ADD executes normally. rst at BUSY cycle 8 -> stall_mul=0 and Status=0 immediately.

Source files
------------

// File: rtl/exe_stage.sv
// exe_stage: execute stage of the 5-stage ARM pipeline.
//   Builds the second ALU operand (Val2), runs the ALU, owns the NZCV status
//   register, computes the branch target and runs MUL as a 16-step radix-4
//   iterative multiply that stalls the upstream stages while it runs.
//
// Ports:
//   clk, rst                         clock (rising edge), async active-high reset
//   flush                            squash: aborts MUL, blocks status update
//   PC                               PC+4 of the instruction in EX
//   WB_EN, MEM_R_EN, MEM_W_EN, B, S  control bits from ID/EX
//   EXE_CMD                          ALU opcode
//   Val_Rn, Val_Rm                   register operands
//   imm, Shift_operand               shifter operand select and field
//   Signed_imm_24                    branch offset (words)
//   ALU_Res                          ALU / MUL result
//   Br_Addr                          branch target
//   Status                           {N,Z,C,V}
//   stall_mul                        freeze request while MUL is running
//   WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out  control pass-through, bubbled on stall
//
// MUL sequencer states:
//   state | meaning
//   IDLE  | no MUL in flight; a MUL presented here launches (stall asserted)
//   BUSY  | one radix-4 step per cycle, stall asserted
//   DONE  | product on ALU_Res, stall released, N/Z updated if S
module exe_stage #(
  parameter int N          = 32,
  parameter int MUL_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [N-1:0] PC,
  input  logic         WB_EN,
  input  logic         MEM_R_EN,
  input  logic         MEM_W_EN,
  input  logic         B,
  input  logic         S,
  input  logic [3:0]   EXE_CMD,
  input  logic [N-1:0] Val_Rn,
  input  logic [N-1:0] Val_Rm,
  input  logic         imm,
  input  logic [11:0]  Shift_operand,
  input  logic [23:0]  Signed_imm_24,
  output logic [N-1:0] ALU_Res,
  output logic [N-1:0] Br_Addr,
  output logic [3:0]   Status,
  output logic         stall_mul,
  output logic         WB_EN_Out,
  output logic         MEM_R_EN_Out,
  output logic         MEM_W_EN_Out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] CMD_MUL = 4'b1010;

  logic [1:0]  state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [3:0]  cnt;

  logic [31:0] val2;
  logic [31:0] alu_res;
  logic [3:0]  flags_next;
  logic        op_defined;
  logic [32:0] sum;
  logic        cin;
  logic        is_mul;
  logic        mul_launch;
  logic [31:0] partial;

  // Branch decode is resolved in ID; B is carried through ID/EX only.
  logic unused_b;
  assign unused_b = B;

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] s);
    ror32 = (x >> s) | (x << (6'd32 - {1'b0, s}));
  endfunction

  // Val2 generation
  always_comb begin
    val2 = '0;
    if (MEM_R_EN | MEM_W_EN) begin
      val2 = {{20{Shift_operand[11]}}, Shift_operand};
    end else if (imm) begin
      val2 = ror32({24'b0, Shift_operand[7:0]}, {Shift_operand[11:8], 1'b0});
    end else begin
      case (Shift_operand[6:5])
        2'b00:   val2 = Val_Rm << Shift_operand[11:7];
        2'b01:   val2 = Val_Rm >> Shift_operand[11:7];
        2'b10:   val2 = $unsigned($signed(Val_Rm) >>> Shift_operand[11:7]);
        default: val2 = ror32(Val_Rm, Shift_operand[11:7]);
      endcase
    end
  end

  // ALU and next flags
  assign cin = Status[1];

  always_comb begin
    alu_res    = '0;
    flags_next = Status;
    op_defined = 1'b1;
    sum        = '0;
    case (EXE_CMD)
      4'b0001: alu_res = val2;
      4'b1001: alu_res = ~val2;
      4'b0010, 4'b0011: begin
        sum = {1'b0, Val_Rn} + {1'b0, val2} + {32'b0, (EXE_CMD[0] & cin)};
        alu_res       = sum[31:0];
        flags_next[1] = sum[32];
        flags_next[0] = (Val_Rn[31] == val2[31]) && (sum[31] != Val_Rn[31]);
      end
      4'b0100, 4'b0101: begin
        // Subtract as Rn + ~Val2 + 1 (SUB) or + C (SBC); carry out is NOT borrow.
        sum = {1'b0, Val_Rn} + {1'b0, ~val2} + {32'b0, (EXE_CMD[0] ? cin : 1'b1)};
        alu_res       = sum[31:0];
        flags_next[1] = sum[32];
        flags_next[0] = (Val_Rn[31] != val2[31]) && (sum[31] != Val_Rn[31]);
      end
      4'b0110: alu_res = Val_Rn & val2;
      4'b0111: alu_res = Val_Rn | val2;
      4'b1000: alu_res = Val_Rn ^ val2;
      CMD_MUL: alu_res = acc;
      default: op_defined = 1'b0;
    endcase
    if (op_defined) begin
      flags_next[3] = alu_res[31];
      flags_next[2] = (alu_res == 32'b0);
    end
  end

  // MUL control
  assign is_mul     = (EXE_CMD == CMD_MUL);
  assign mul_launch = (state == IDLE) && is_mul && !flush;
  // Gated by rst so the freeze drops the instant reset asserts, even if a
  // MUL is still presented on the inputs.
  assign stall_mul  = !rst && (mul_launch || (state == BUSY));

  always_comb begin
    partial = '0;
    case (mplier[1:0])
      2'b00:   partial = '0;
      2'b01:   partial = mcand;
      2'b10:   partial = mcand << 1;
      default: partial = mcand + (mcand << 1);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_launch) begin
            mcand  <= Val_Rn;
            mplier <= Val_Rm;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc    <= acc + (partial << {cnt, 1'b0});
            mplier <= mplier >> 2;
            cnt    <= cnt + 4'd1;
            if (cnt == 4'(MUL_CYCLES - 1)) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status register. MUL reaches here unstalled only in DONE, where
  // flags_next carries N/Z of the product and keeps C/V.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Status <= 4'b0;
    end else if (S && !flush && !stall_mul && op_defined) begin
      Status <= flags_next;
    end
  end

  assign ALU_Res      = alu_res;
  assign Br_Addr      = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};
  assign WB_EN_Out    = WB_EN    & ~stall_mul;
  assign MEM_R_EN_Out = MEM_R_EN & ~stall_mul;
  assign MEM_W_EN_Out = MEM_W_EN & ~stall_mul;

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic        clk, rst, flush;
  logic [31:0] PC;
  logic        WB_EN, MEM_R_EN, MEM_W_EN, B, S;
  logic [3:0]  EXE_CMD;
  logic [31:0] Val_Rn, Val_Rm;
  logic        imm;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic [31:0] ALU_Res, Br_Addr;
  logic [3:0]  Status;
  logic        stall_mul, WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: m_phase counts cycles since a MUL launched
  // (0 = none in flight, 1..16 = iterating, 17 = result cycle).
  int          m_phase  = 0;
  logic [3:0]  m_status = 4'b0;
  logic [31:0] m_prod   = 32'b0;

  exe_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .PC(PC),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .B(B), .S(S),
    .EXE_CMD(EXE_CMD), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm),
    .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24),
    .ALU_Res(ALU_Res), .Br_Addr(Br_Addr), .Status(Status), .stall_mul(stall_mul),
    .WB_EN_Out(WB_EN_Out), .MEM_R_EN_Out(MEM_R_EN_Out), .MEM_W_EN_Out(MEM_W_EN_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_val2(input logic mr, input logic mw, input logic im,
                                             input logic [11:0] so, input logic [31:0] rm);
    logic [63:0] d;
    logic [31:0] x;
    int amt;
    if (mr || mw) return 32'($signed(so));
    if (im) begin
      x   = {24'b0, so[7:0]};
      d   = {x, x};
      amt = 2 * int'(so[11:8]);
      d   = d >> amt;
      return d[31:0];
    end
    amt = int'(so[11:7]);
    case (so[6:5])
      2'd0:    return rm << amt;
      2'd1:    return rm >> amt;
      2'd2:    return 32'($signed(rm) >>> amt);
      default: begin d = {rm, rm}; d = d >> amt; return d[31:0]; end
    endcase
  endfunction

  function automatic void model_alu(input logic [3:0] cmd, input logic [31:0] rn,
                                    input logic [31:0] v2, input logic [3:0] st,
                                    output logic [31:0] res, output logic [3:0] nst,
                                    output bit def);
    longint unsigned u;
    longint sg;
    longint b;
    bit cin;
    cin = st[1];
    res = 32'b0; nst = st; def = 1;
    case (cmd)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd2, 4'd3: begin
        b   = (cmd == 4'd3) ? longint'(cin) : 0;
        u   = longint'(rn) + longint'(v2) + b;
        res = u[31:0];
        nst[1] = u[32];
        sg  = longint'($signed(rn)) + longint'($signed(v2)) + b;
        nst[0] = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        b   = (cmd == 4'd5) ? longint'(!cin) : 0;
        u   = longint'(rn) - longint'(v2) - b;
        res = u[31:0];
        nst[1] = (longint'(rn) >= longint'(v2) + b);
        sg  = longint'($signed(rn)) - longint'($signed(v2)) - b;
        nst[0] = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
      end
      4'd6: res = rn & v2;
      4'd7: res = rn | v2;
      4'd8: res = rn ^ v2;
      default: def = 0;
    endcase
    if (def) begin
      nst[3] = res[31];
      nst[2] = (res == 32'b0);
    end
  endfunction

  // Model update on the clock edge
  always @(posedge clk or posedge rst) begin : model
    logic [31:0] r;
    logic [3:0]  ns;
    bit d;
    if (rst) begin
      m_phase  = 0;
      m_status = 4'b0;
    end else if (m_phase == 0) begin
      if (EXE_CMD == 4'd10 && !flush) begin
        m_phase = 1;
        m_prod  = Val_Rn * Val_Rm;
      end else if (S && !flush && EXE_CMD != 4'd10) begin
        model_alu(EXE_CMD, Val_Rn,
                  model_val2(MEM_R_EN, MEM_W_EN, imm, Shift_operand, Val_Rm),
                  m_status, r, ns, d);
        if (d) m_status = ns;
      end
    end else if (m_phase <= 16) begin
      m_phase = flush ? 0 : m_phase + 1;
    end else begin
      if (S && !flush) m_status[3:2] = {m_prod[31], m_prod == 32'b0};
      m_phase = 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    logic [31:0] er;
    logic [3:0]  ns;
    bit d;
    logic es;
    es = !rst && ((m_phase == 0 && EXE_CMD == 4'd10 && !flush) || (m_phase >= 1 && m_phase <= 16));
    chk("stall_mul", stall_mul, es);
    chk("status", Status, m_status);
    chk("br_addr", Br_Addr, PC + 32'($signed(Signed_imm_24)) * 32'd4);
    chk("ctrl_out", {WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out},
        es ? 3'b000 : {WB_EN, MEM_R_EN, MEM_W_EN});
    if (!es) begin
      if (m_phase == 17) begin
        chk("mul_res", ALU_Res, m_prod);
      end else if (EXE_CMD != 4'd10) begin
        model_alu(EXE_CMD, Val_Rn,
                  model_val2(MEM_R_EN, MEM_W_EN, imm, Shift_operand, Val_Rm),
                  m_status, er, ns, d);
        chk("alu_res", ALU_Res, er);
      end
    end
  end

  task automatic set_op(input logic [3:0] cmd, input logic s_bit, input logic i_bit,
                        input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm);
    EXE_CMD = cmd; S = s_bit; imm = i_bit; Shift_operand = so;
    Val_Rn = rn; Val_Rm = rm;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; WB_EN = 1'b1; B = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts stalled cycles; returns at the negedge of the first unstalled cycle.
  task automatic wait_mul(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall_mul) break;
      n++;
      tick();
    end
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFFFFFF;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin : drive
    int  n;
    bit  hold;
    rst = 1'b0; PC = 32'h0; Signed_imm_24 = 24'h0;
    set_op(4'd0, 0, 0, 12'h0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset_status", Status, 4'b0000);
    chk("reset_stall", stall_mul, 1'b0);
    tick();
    rst = 1'b0;

    set_op(4'd2, 1, 1, 12'h007, 32'd5, 32'd0);
    PC = 32'h1000; Signed_imm_24 = 24'hFFFFFE;
    @(negedge clk);
    chk("add_res", ALU_Res, 32'd12);
    chk("br_addr_lit", Br_Addr, 32'h00000FF8);
    tick();
    chk("add_status", Status, 4'b0000);

    set_op(4'd2, 1, 1, 12'h001, 32'h7FFFFFFF, 32'd0);
    @(negedge clk); chk("add_ovf_res", ALU_Res, 32'h80000000);
    tick();         chk("add_ovf_status", Status, 4'b1001);

    set_op(4'd4, 1, 1, 12'h005, 32'd3, 32'd0);
    @(negedge clk); chk("sub_res", ALU_Res, 32'hFFFFFFFE);
    tick();         chk("sub_status", Status, 4'b1000);

    set_op(4'd3, 0, 1, 12'h001, 32'd1, 32'd0);
    @(negedge clk); chk("adc_res", ALU_Res, 32'd2);
    tick();

    set_op(4'd1, 0, 0, 12'h0C0, 32'd0, 32'h80000001);
    @(negedge clk); chk("mov_asr", ALU_Res, 32'hC0000000);
    tick();

    set_op(4'd1, 0, 1, 12'h2FF, 32'd0, 32'd0);
    @(negedge clk); chk("mov_rot", ALU_Res, 32'hF000000F);
    tick();

    set_op(4'd2, 0, 0, 12'hFFC, 32'h100, 32'd0);
    WB_EN = 1'b0; MEM_W_EN = 1'b1;
    @(negedge clk);
    chk("str_addr", ALU_Res, 32'h000000FC);
    chk("str_memw", MEM_W_EN_Out, 1'b1);
    tick();

    set_op(4'd4, 1, 1, 12'h003, 32'd5, 32'd0);
    @(negedge clk); chk("cmp_res", ALU_Res, 32'd2);
    tick();         chk("cmp_status", Status, 4'b0010);

    set_op(4'd10, 1, 0, 12'h0, 32'h00010003, 32'd7);
    wait_mul(n);
    chk("mul_stall_cycles", n, 17);
    chk("mul_res_lit", ALU_Res, 32'h00070015);
    tick();
    chk("mul_status", Status, 4'b0010);

    set_op(4'd10, 0, 0, 12'h0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_mul(n);
    chk("mul2_stall_cycles", n, 17);
    chk("mul2_res_lit", ALU_Res, 32'h00000001);
    tick();

    set_op(4'd10, 1, 0, 12'h0, 32'd3, 32'd3);
    repeat (5) tick();
    flush = 1'b1;
    tick();
    set_op(4'd2, 1, 1, 12'h001, 32'hFFFFFFFF, 32'd0);
    chk("flush_stall", stall_mul, 1'b0);
    chk("flush_status", Status, 4'b0010);
    @(negedge clk); chk("post_flush_add", ALU_Res, 32'd0);
    tick();         chk("post_flush_status", Status, 4'b0110);

    set_op(4'd10, 0, 0, 12'h0, 32'd5, 32'd6);
    repeat (8) tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_stall", stall_mul, 1'b0);
    chk("rst_mid_status", Status, 4'b0000);
    set_op(4'd0, 0, 0, 12'h0, 32'd0, 32'd0);
    tick();
    rst = 1'b0;

    hold = 0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (!hold) begin
        EXE_CMD = ($urandom_range(0, 9) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
        S = 1'($urandom_range(0, 1));
        imm = 1'($urandom_range(0, 1));
        Shift_operand = 12'($urandom_range(0, 4095));
        Val_Rn = pick32();
        Val_Rm = pick32();
        MEM_R_EN = ($urandom_range(0, 5) == 0);
        MEM_W_EN = ($urandom_range(0, 5) == 0);
        WB_EN = 1'($urandom_range(0, 1));
        B = 1'($urandom_range(0, 1));
        PC = $urandom;
        Signed_imm_24 = 24'($urandom);
      end
      flush = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      hold = stall_mul && !flush;
    end

    tick();
    set_op(4'd0, 0, 0, 12'h0, 32'd0, 32'd0);
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
